ibex_csr_arbiter: RTL and testbench
===================================

# ibex_csr_arbiter

Arbitrated access sequencer for a bank of `ibex_csr` register instances. It shares the bank between `NumReq` requesters, for example the core pipeline and the debug module. Each transaction is sequenced as grant, access and response. It performs read, write, set and clear (read-modify-write) operations, and reports out-of-range addresses, writes to read-only entries and shadow-copy read errors back to the requester.

## Interface
Parameters:
- `NumReq`, default 2: number of requesters, 2..4.
- `NumCsr`, default 8: number of CSR entries in the bank, 1..16.
- `Width`, default 32: CSR data width.
- `AddrWidth`, default 4: request address width; must satisfy 2^AddrWidth ≥ NumCsr.
- `ReadOnlyMask`, default '0: bit *i* set means CSR *i* rejects write, set and clear.

Ports (per-requester buses are flattened, requester *r* occupying slice *r*):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  NumReq  request valid; held until granted.
- `op_i`  in  2×NumReq  operation code: 00 read, 01 write, 10 set, 11 clear.
- `addr_i`  in  AddrWidth×NumReq  CSR index.
- `wdata_i`  in  Width×NumReq  write data or mask.
- `gnt_o`  out  NumReq  one-hot grant; payload is sampled in the grant cycle.
- `rvalid_o`  out  NumReq  one-hot response valid, asserted for one cycle.
- `rdata_o`  out  Width  pre-operation CSR value, valid with `rvalid_o`.
- `err_o`  out  1  error flag, valid with `rvalid_o`.
- `csr_wr_en_o`  out  NumCsr  one-hot write enable to the bank.
- `csr_wr_data_o`  out  Width  write data to the bank; common to all entries.
- `csr_rd_data_i`  in  Width×NumCsr  current value of each CSR.
- `csr_rd_error_i`  in  NumCsr  shadow mismatch flag of each CSR.

## Operation
- The state machine has three states: IDLE, ACCESS and RESP.
- **IDLE**
  - If any `req_i` bit is set, grant exactly one requester, selected round-robin starting at `prio_q`.
  - `gnt_o` is combinational from `req_i` and `prio_q`, and asserts only in IDLE.
  - On grant: latch the requester index, `op_i`, `addr_i` and `wdata_i`; set `prio_q` to (index+1) mod NumReq; go to ACCESS.
- **ACCESS**
  - Capture `old` = `csr_rd_data_i[addr]` and `rderr` = `csr_rd_error_i[addr]`.
  - Compute `new` from the latched op:
    - write: `new` = wdata.
    - set: `new` = old | wdata.
    - clear: `new` = old & ~wdata.
  - For any op other than read, and only if the address is valid and `ReadOnlyMask[addr]` is 0:
    - drive `csr_wr_en_o[addr]` = 1;
    - drive `csr_wr_data_o` = `new`.
  - Go to RESP.
- **RESP**
  - Assert `rvalid_o[index]` for one cycle.
  - `rdata_o` = registered `old`.
  - `err_o` is the OR of three conditions:
    - address out of range;
    - non-read op to a read-only CSR;
    - `rderr`.
  - Go to IDLE.
- Out-of-range address (addr ≥ NumCsr): no write enable, `rdata_o` = 0, `err_o` = 1.
- Set or clear with `wdata` = 0 still asserts the write enable, writing back the unchanged value.
- A read never asserts any `csr_wr_en_o` bit.
- A shadow error does not suppress the write; it is reported only.

## Timing
- Reset values:
  - state IDLE, `prio_q` = 0.
  - `gnt_o`, `rvalid_o`, `csr_wr_en_o` are all 0.
  - `rdata_o`, `csr_wr_data_o` = 0; `err_o` = 0.
- Latency:
  - grant in cycle T;
  - bank write enable in T+1, with the new value visible on `csr_rd_data_i` in T+2;
  - response in T+2.
- The next grant is possible in T+3. Maximum throughput is one transaction per 3 cycles.
- `csr_wr_en_o` is at most one-hot and asserts only in ACCESS.
- `gnt_o` and `rvalid_o` are each at most one-hot.
- A requester must keep `req_i` and its payload stable until `gnt_o`. It may deassert `req_i` or issue a new request in the cycle after the grant.
  - A request still held in RESP or ACCESS is not granted until the next IDLE cycle.
- Simultaneous requests: the lowest index at or above `prio_q` wins, wrapping around.
- Requests arriving during ACCESS or RESP wait; they are never dropped.
- Reset during ACCESS or RESP aborts the transaction:
  - no `rvalid_o`;
  - `csr_wr_en_o` drops immediately, since reset is asynchronous;
  - a bank write is guaranteed only if its clock edge occurred before reset.
- `rdata_o` and `err_o` are don't-care outside RESP; they hold their last value.

## Test plan
- **Write then read:** requester 0 writes 0xDEADBEEF to CSR 3, then reads CSR 3 → write enable bit 3 asserted once, with data 0xDEADBEEF; the read response has rdata 0xDEADBEEF and err 0.
- **Set and clear:** with CSR 2 = 0x0000_00F0, set with 0x0F, then clear with 0xF0 → the responses return 0xF0 and then 0xFF; CSR 2 ends at 0x0F.
- **Round-robin:** `req_i` = 2'b11 held continuously with `prio_q` = 0 → grants alternate 0, 1, 0, 1, each 3 cycles apart, with no requester starved.
- **Error paths:**
  - read address 12 with NumCsr 8 → rdata 0, err 1, no write enable;
  - write to a CSR whose `ReadOnlyMask` bit is set → err 1, no write enable, rdata equals the old value;
  - `csr_rd_error_i` set on a read → err 1.
- **Reset mid-transaction:** assert `rst_ni` low in ACCESS → all outputs 0 immediately; after release, the first grant goes to the lowest active requester, since `prio_q` = 0.
- **Request timing:** a request asserted during RESP → granted in the following IDLE cycle; `gnt_o` is never asserted outside IDLE (assertion check).

Source files
------------

// File: rtl/ibex_csr_arbiter.sv
// Round-robin arbiter that lets NumReq masters share one bank of ibex_csr registers.
// Each transaction runs IDLE (grant) -> ACCESS (bank read/modify/write) -> RESP.
module ibex_csr_arbiter #(
  parameter int unsigned        NumReq       = 2,
  parameter int unsigned        NumCsr       = 8,
  parameter int unsigned        Width        = 32,
  parameter int unsigned        AddrWidth    = 4,
  parameter logic [NumCsr-1:0]  ReadOnlyMask = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_i,
  input  logic [2*NumReq-1:0]         op_i,
  input  logic [AddrWidth*NumReq-1:0] addr_i,
  input  logic [Width*NumReq-1:0]     wdata_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumReq-1:0]           rvalid_o,
  output logic [Width-1:0]            rdata_o,
  output logic                        err_o,
  output logic [NumCsr-1:0]           csr_wr_en_o,
  output logic [Width-1:0]            csr_wr_data_o,
  input  logic [Width*NumCsr-1:0]     csr_rd_data_i,
  input  logic [NumCsr-1:0]           csr_rd_error_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                r_state;
  logic [IdxW-1:0]       r_prio;
  logic [IdxW-1:0]       r_idx;
  logic [1:0]            r_op;
  logic [AddrWidth-1:0]  r_addr;
  logic [Width-1:0]      r_wdata;
  logic [NumReq-1:0]     r_rvalid;
  logic [Width-1:0]      r_rdata;
  logic                  r_err;

  logic [1:0]            w_op    [NumReq];
  logic [AddrWidth-1:0]  w_addr  [NumReq];
  logic [Width-1:0]      w_wdata [NumReq];
  logic [Width-1:0]      w_csr_data [NumCsr];
  logic [NumCsr-1:0]     w_csr_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_req
      assign w_op[gi]    = op_i[2*gi +: 2];
      assign w_addr[gi]  = addr_i[AddrWidth*gi +: AddrWidth];
      assign w_wdata[gi] = wdata_i[Width*gi +: Width];
    end
    for (gi = 0; gi < NumCsr; gi++) begin : g_csr
      assign w_csr_data[gi] = csr_rd_data_i[Width*gi +: Width];
      assign w_csr_sel[gi]  = (r_addr == AddrWidth'(gi));
    end
  endgenerate

  // Winner is the active requester with the smallest rotating distance from r_prio.
  logic                  w_win_found;
  logic [IdxW-1:0]       w_win_idx;
  logic [1:0]            w_win_op;
  logic [AddrWidth-1:0]  w_win_addr;
  logic [Width-1:0]      w_win_wdata;
  int                    w_dist;
  int                    w_best_dist;

  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_win_op    = '0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    w_dist      = 0;
    w_best_dist = 0;
    for (int i = 0; i < int'(NumReq); i++) begin
      w_dist = (i + int'(NumReq) - int'(r_prio)) % int'(NumReq);
      if (req_i[i] && (!w_win_found || (w_dist < w_best_dist))) begin
        w_win_found = 1'b1;
        w_best_dist = w_dist;
        w_win_idx   = IdxW'(i);
        w_win_op    = w_op[i];
        w_win_addr  = w_addr[i];
        w_win_wdata = w_wdata[i];
      end
    end
  end

  logic w_grant;
  assign w_grant = rst_ni && (r_state == IDLE) && w_win_found;
  assign gnt_o   = w_grant ? (NumReq'(1) << w_win_idx) : '0;

  // Out-of-range addresses match no entry, so w_hit doubles as the range check.
  logic              w_hit;
  logic [Width-1:0]  w_old;
  logic              w_rderr;
  logic              w_ro;

  always_comb begin
    w_hit   = 1'b0;
    w_old   = '0;
    w_rderr = 1'b0;
    w_ro    = 1'b0;
    for (int i = 0; i < int'(NumCsr); i++) begin
      if (w_csr_sel[i]) begin
        w_hit   = 1'b1;
        w_old   = w_csr_data[i];
        w_rderr = csr_rd_error_i[i];
        w_ro    = ReadOnlyMask[i];
      end
    end
  end

  logic [Width-1:0] w_new;
  logic             w_is_read;
  logic             w_we;
  logic             w_err;

  always_comb begin
    case (r_op)
      OpRead:  w_new = w_old;
      OpWrite: w_new = r_wdata;
      OpSet:   w_new = w_old | r_wdata;
      OpClear: w_new = w_old & ~r_wdata;
    endcase
  end

  assign w_is_read = (r_op == OpRead);
  assign w_we      = (r_state == ACCESS) && !w_is_read && w_hit && !w_ro;
  assign w_err     = !w_hit || (!w_is_read && w_ro) || w_rderr;

  assign csr_wr_en_o   = w_we ? w_csr_sel : '0;
  assign csr_wr_data_o = w_we ? w_new : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_prio   <= '0;
      r_idx    <= '0;
      r_op     <= OpRead;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_idx   <= w_win_idx;
            r_op    <= w_win_op;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
            r_prio  <= (w_win_idx == IdxW'(NumReq - 1)) ? '0 : (w_win_idx + IdxW'(1));
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_rdata  <= w_hit ? w_old : '0;
          r_err    <= w_err;
          r_rvalid <= NumReq'(1) << r_idx;
          r_state  <= RESP;
        end
        RESP: begin
          r_rvalid <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

endmodule

// File: tb/tb_ibex_csr_arbiter.sv
// Bench for ibex_csr_arbiter: directed scenarios plus random traffic from three requesters,
// with a transaction-level reference model feeding a response scoreboard.
module tb_ibex_csr_arbiter;

  localparam int NR = 3;
  localparam int NC = 8;
  localparam logic [NC-1:0] ROM = 8'h81;

  logic               clk_i;
  logic               rst_ni;
  logic [NR-1:0]      req;
  logic [2*NR-1:0]    op_i;
  logic [4*NR-1:0]    addr_i;
  logic [32*NR-1:0]   wdata_i;
  logic [NR-1:0]      gnt_o;
  logic [NR-1:0]      rvalid_o;
  logic [31:0]        rdata_o;
  logic               err_o;
  logic [NC-1:0]      csr_wr_en_o;
  logic [31:0]        csr_wr_data_o;
  logic [32*NC-1:0]   csr_rd_data_i;
  logic [NC-1:0]      csr_rd_error_i;

  logic [1:0]  t_op    [NR];
  logic [3:0]  t_addr  [NR];
  logic [31:0] t_wdata [NR];
  logic [31:0] bank    [NC];
  logic [NC-1:0] err_vec;

  int checks = 0;
  int errors = 0;

  ibex_csr_arbiter #(
    .NumReq(NR), .NumCsr(NC), .Width(32), .AddrWidth(4), .ReadOnlyMask(ROM)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .csr_wr_en_o(csr_wr_en_o), .csr_wr_data_o(csr_wr_data_o),
    .csr_rd_data_i(csr_rd_data_i), .csr_rd_error_i(csr_rd_error_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_comb begin
    op_i    = '0;
    addr_i  = '0;
    wdata_i = '0;
    for (int i = 0; i < NR; i++) begin
      op_i[2*i +: 2]     = t_op[i];
      addr_i[4*i +: 4]   = t_addr[i];
      wdata_i[32*i +: 32] = t_wdata[i];
    end
  end

  always_comb begin
    csr_rd_data_i = '0;
    for (int i = 0; i < NC; i++) csr_rd_data_i[32*i +: 32] = bank[i];
  end
  assign csr_rd_error_i = err_vec;

  function automatic logic [31:0] init_val(input int i);
    return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural CSR bank driven by the DUT's write port.
  initial begin
    for (int i = 0; i < NC; i++) bank[i] = init_val(i);
    forever begin
      @(posedge clk_i);
      for (int i = 0; i < NC; i++) if (csr_wr_en_o[i]) bank[i] <= csr_wr_data_o;
    end
  end

  // Reference model + scoreboard: one transaction every 3 cycles at most, grants round-robin.
  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int          resp_count = 0;
  int          we_count   = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  logic [31:0] last_we_data;
  logic [NC-1:0] last_we_vec;

  initial begin
    logic [31:0] model_csr [NC];
    int cyc, last_gnt, model_prio, win, pend_idx, pend_cyc;
    bit pend_v;
    logic [1:0] pend_op;
    logic [3:0] pend_addr;
    logic [31:0] pend_wd, old, nv;
    logic [NR-1:0] exp_g;
    logic [NC-1:0] exp_we;
    bit hit, ro, weok;
    exp_t e;
    for (int i = 0; i < NC; i++) model_csr[i] = init_val(i);
    cyc = 0; last_gnt = -100; model_prio = 0; pend_v = 0;
    pend_idx = 0; pend_cyc = 0; pend_op = 0; pend_addr = 0; pend_wd = 0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        q.delete();
        last_gnt = -100; model_prio = 0; pend_v = 0;
      end else begin
        exp_g = '0; win = -1;
        if (req != 0 && cyc >= last_gnt + 3)
          for (int k = 0; k < NR; k++) begin
            int r;
            r = (model_prio + k) % NR;
            if (win < 0 && req[r]) win = r;
          end
        if (win >= 0) exp_g = NR'(1) << win;
        if (gnt_o != 0 || exp_g != 0) chk("grant", 32'(gnt_o), 32'(exp_g));
        if (win >= 0) begin
          pend_idx = win; pend_op = t_op[win]; pend_addr = t_addr[win]; pend_wd = t_wdata[win];
          pend_cyc = cyc; pend_v = 1; last_gnt = cyc; model_prio = (win + 1) % NR;
        end else if (pend_v && cyc == pend_cyc + 1) begin
          hit = (int'(pend_addr) < NC);
          old = 32'h0; ro = 0;
          if (hit) begin old = model_csr[pend_addr]; ro = ROM[pend_addr]; end
          case (pend_op)
            2'b01:   nv = pend_wd;
            2'b10:   nv = old | pend_wd;
            2'b11:   nv = old & ~pend_wd;
            default: nv = old;
          endcase
          weok = (pend_op != 2'b00) && hit && !ro;
          exp_we = weok ? (NC'(1) << pend_addr) : '0;
          chk("wr_en", 32'(csr_wr_en_o), 32'(exp_we));
          if (weok) begin
            chk("wr_data", csr_wr_data_o, nv);
            model_csr[pend_addr] = nv;
          end
          e.idx = pend_idx; e.rdata = old; e.cyc = pend_cyc + 2;
          e.err = !hit || ((pend_op != 2'b00) && ro) || (hit && err_vec[pend_addr]);
          q.push_back(e);
          pend_v = 0;
        end else if (csr_wr_en_o != 0) begin
          chk("wr_en_outside_access", 32'(csr_wr_en_o), 32'h0);
        end
        if (csr_wr_en_o != 0) begin
          we_count++; last_we_data = csr_wr_data_o; last_we_vec = csr_wr_en_o;
        end
        if (rvalid_o != 0) begin
          if (q.size() == 0) chk("rvalid_unexpected", 32'(rvalid_o), 32'h0);
          else begin
            e = q.pop_front();
            chk("rvalid_vec", 32'(rvalid_o), 32'(NR'(1) << e.idx));
            chk("rdata", rdata_o, e.rdata);
            chk("err", 32'(err_o), 32'(e.err));
            chk("resp_cycle", 32'(cyc), 32'(e.cyc));
          end
          $display("resp r%0d rdata=%h err=%0d", $clog2(32'(rvalid_o)), rdata_o, err_o);
          last_rdata = rdata_o; last_err = err_o; resp_count++;
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
          chk("rvalid_missing", 32'(rvalid_o), 32'(NR'(1) << q[0].idx));
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic wait_gnt(input int r);
    bit seen;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (gnt_o[r]) begin seen = 1; break; end
    end
    if (!seen) chk("gnt_timeout", 32'(gnt_o), 32'(NR'(1) << r));
    @(posedge clk_i); #1;
    req[r] = 1'b0;
  endtask

  task automatic txn(input int r, input logic [1:0] op, input logic [3:0] a, input logic [31:0] wd);
    int prev;
    prev = resp_count;
    t_op[r] = op; t_addr[r] = a; t_wdata[r] = wd; req[r] = 1'b1;
    wait_gnt(r);
    for (int n = 0; n < 10 && resp_count == prev; n++) @(posedge clk_i);
    #1;
    if (resp_count == prev) chk("resp_timeout", 32'(resp_count), 32'(prev + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, gidx [$], gcyc [$];
    logic [31:0] old7, old4;
    logic [NR-1:0] g;
    rst_ni = 1'b0; req = '1; err_vec = '0;
    for (int i = 0; i < NR; i++) begin t_op[i] = 2'b00; t_addr[i] = 4'(i); t_wdata[i] = '0; end
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_wr_en", 32'(csr_wr_en_o), 32'h0);
    chk("rst_wr_data", csr_wr_data_o, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    req = 3'b011;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Round-robin with requesters 0 and 1 held.
    for (int c = 0; c < 13; c++) begin
      @(negedge clk_i);
      if (gnt_o != 0) begin gidx.push_back($clog2(32'(gnt_o))); gcyc.push_back(c); end
    end
    @(posedge clk_i); #1;
    req = '0;
    chk("rr_count", 32'(gidx.size()), 32'd5);
    for (int k = 0; k < gidx.size(); k++) begin
      chk("rr_order", 32'(gidx[k]), 32'(k % 2));
      chk("rr_spacing", 32'(gcyc[k]), 32'(3 * k));
    end
    repeat (5) @(posedge clk_i);
    #1;

    we0 = we_count;
    txn(0, 2'b01, 4'd3, 32'hDEAD_BEEF);
    chk("wr3_count", 32'(we_count - we0), 32'd1);
    chk("wr3_vec", 32'(last_we_vec), 32'h08);
    chk("wr3_data", last_we_data, 32'hDEAD_BEEF);
    txn(0, 2'b00, 4'd3, 32'h0);
    chk("rd3_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("rd3_err", 32'(last_err), 32'h0);

    txn(1, 2'b01, 4'd2, 32'h0000_00F0);
    txn(0, 2'b10, 4'd2, 32'h0000_000F);
    chk("set_rdata", last_rdata, 32'h0000_00F0);
    txn(1, 2'b11, 4'd2, 32'h0000_00F0);
    chk("clr_rdata", last_rdata, 32'h0000_00FF);
    chk("csr2_final", bank[2], 32'h0000_000F);

    we0 = we_count;
    txn(0, 2'b00, 4'd12, 32'h0);
    chk("oor_rdata", last_rdata, 32'h0);
    chk("oor_err", 32'(last_err), 32'h1);
    chk("oor_no_we", 32'(we_count - we0), 32'h0);
    old7 = bank[7];
    txn(1, 2'b01, 4'd7, 32'h1234_5678);
    chk("ro_err", 32'(last_err), 32'h1);
    chk("ro_rdata", last_rdata, old7);
    chk("ro_no_we", 32'(we_count - we0), 32'h0);
    txn(2, 2'b10, 4'd5, 32'h0);
    chk("set0_we", 32'(we_count - we0), 32'h1);
    err_vec = 8'h20;
    txn(0, 2'b00, 4'd5, 32'h0);
    chk("shadow_err", 32'(last_err), 32'h1);
    chk("shadow_rdata", last_rdata, init_val(5));
    err_vec = '0;

    // Request raised during RESP is granted in the next IDLE cycle.
    t_op[0] = 2'b00; t_addr[0] = 4'd1; req[0] = 1'b1;
    wait_gnt(0);
    @(posedge clk_i); #1;
    t_op[1] = 2'b00; t_addr[1] = 4'd2; req[1] = 1'b1;
    @(negedge clk_i);
    chk("gnt_in_resp", 32'(gnt_o), 32'h0);
    @(negedge clk_i);
    chk("gnt_after_resp", 32'(gnt_o), 32'h2);
    @(posedge clk_i); #1;
    req[1] = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;

    // Reset in ACCESS aborts the write.
    old4 = bank[4];
    t_op[1] = 2'b01; t_addr[1] = 4'd4; t_wdata[1] = ~old4; req[1] = 1'b1;
    wait_gnt(1);
    chk("we_in_access", 32'(csr_wr_en_o), 32'h10);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_we", 32'(csr_wr_en_o), 32'h0);
    chk("mid_rst_wdata", csr_wr_data_o, 32'h0);
    chk("mid_rst_gnt", 32'(gnt_o), 32'h0);
    chk("mid_rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("mid_rst_err", 32'(err_o), 32'h0);
    t_op[1] = 2'b00; t_op[2] = 2'b00; t_addr[2] = 4'd6;
    req = 3'b110;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("gnt_after_rst", 32'(gnt_o), 32'h2);
    @(posedge clk_i); #1;
    req[1] = 1'b0;
    wait_gnt(2);
    chk("aborted_write", bank[4], old4);
    repeat (4) @(posedge clk_i);
    #1;

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_i);
      g = gnt_o;
      @(posedge clk_i); #1;
      for (int r = 0; r < NR; r++) begin
        if (g[r] || !req[r]) begin
          req[r]     = ($urandom_range(0, 2) == 0);
          t_op[r]    = 2'($urandom_range(0, 3));
          t_addr[r]  = 4'($urandom_range(0, 11));
          t_wdata[r] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        end
      end
      if ($urandom_range(0, 15) == 0) err_vec = NC'($urandom) & NC'($urandom);
    end
    for (int c = 0; c < 40 && req != 0; c++) begin
      @(negedge clk_i);
      g = gnt_o;
      @(posedge clk_i); #1;
      req = req & ~g;
    end
    chk("drain_req", 32'(req), 32'h0);
    repeat (6) @(posedge clk_i);
    #1;
    chk("queue_empty", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
